// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package md_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational datapath: 64-bit product, or quotient/remainder when MULDIV_DIV_EN
// is defined. Results come out as {HI, LO} plus a divide-by-zero flag.
module muldiv_arith
  import md_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_dz
);

  // Even opcodes (MULT, DIV) are the signed forms.
  logic        w_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;

  assign w_signed = ~i_op[0];
  assign w_ext_a  = {{32{w_signed & i_a[31]}}, i_a};
  assign w_ext_b  = {{32{w_signed & i_b[31]}}, i_b};
  assign w_prod   = w_ext_a * w_ext_b;

`ifdef MULDIV_DIV_EN
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Divide magnitudes unsigned, then restore signs: this truncates toward zero
  // and yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign w_neg_a   = w_signed & i_a[31];
  assign w_neg_b   = w_signed & i_b[31];
  assign w_mag_a   = w_neg_a ? -i_a : i_a;
  assign w_mag_b   = w_neg_b ? -i_b : i_b;
  assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq      = w_mag_a / w_divisor;
  assign w_ur      = w_mag_a % w_divisor;

  always_comb begin
    o_hi = w_prod[63:32];
    o_lo = w_prod[31:0];
    o_dz = 1'b0;
    if (is_div_op(i_op)) begin
      o_lo = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
      o_hi = w_neg_a ? -w_ur : w_ur;
      o_dz = (i_b == 32'd0);
    end
  end
`else
  assign o_hi = w_prod[63:32];
  assign o_lo = w_prod[31:0];
  assign o_dz = 1'b0;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MUL/DIV sequencer owning HI/LO; holds Busy for a fixed latency then
// commits. DIV/DIVU are accepted only when MULDIV_DIV_EN is defined.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        StallMD,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hold_hi;
  logic [31:0]      r_hold_lo;
  logic             r_hold_dz;

  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_dz;
  logic             w_long_op;

  muldiv_arith u_arith (
    .i_a  (A),
    .i_b  (B),
    .i_op (MDOp),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_dz (w_res_dz)
  );

`ifdef MULDIV_DIV_EN
  assign w_long_op = is_mul_op(MDOp) | is_div_op(MDOp);
`else
  assign w_long_op = is_mul_op(MDOp);
`endif

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign HI      = r_hi;
  assign LO      = r_lo;
  assign StallMD = r_busy | (Start & w_long_op);

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // the holding regs are reset too, as they are plain flops, not a memory array.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hold_hi <= '0;
      r_hold_lo <= '0;
      r_hold_dz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (w_long_op) begin
              r_busy    <= 1'b1;
              r_hold_hi <= w_res_hi;
              r_hold_lo <= w_res_lo;
              r_hold_dz <= w_res_dz;
              if (is_mul_op(MDOp)) begin
                r_state <= ST_MUL;
                r_cnt   <= CNT_W'(MULT_CYCLES);
              end else begin
                r_state <= ST_DIV;
                r_cnt   <= CNT_W'(DIV_CYCLES);
              end
            end else if (MDOp == MD_MTHI) begin
              r_hi <= A;
            end else if (MDOp == MD_MTLO) begin
              r_lo <= A;
            end
          end
        end
        default: begin
          // Start is ignored here; the hazard unit keeps it away while busy.
          if (r_cnt == CNT_W'(1)) begin
            if (!r_hold_dz) begin
              r_hi <= r_hold_hi;
              r_lo <= r_hold_lo;
            end
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; divide vectors run only when MULDIV_DIV_EN is defined.
module tb_muldiv_ctrl;
  import md_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        StallMD;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .StallMD (StallMD),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 Clk = ~Clk;

  // The hazard unit never issues while busy; flag it if the bench ever does.
  always @(posedge Clk) begin
    assert (!(Start && Busy)) else $error("FAIL protocol: Start issued while Busy");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and drop the strobe.
  task automatic step();
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    #1;
  endtask

  // Called in cycle t+1; checks n busy cycles and returns in the Done cycle.
  task automatic busy_phase(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      check({tag, "_stall"}, {31'd0, StallMD}, 32'd1);
      check({tag, "_nodone"}, {31'd0, Done}, 32'd0);
      step();
    end
    check({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = '0;
    B     = '0;
    step();
    step();
    Reset = 1'b0;
    #1;
    check("rst_busy",  {31'd0, Busy},    32'd0);
    check("rst_done",  {31'd0, Done},    32'd0);
    check("rst_stall", {31'd0, StallMD}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // MULT -2 * 3 = -6
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_stall_start", {31'd0, StallMD}, 32'd1);
    step();
    check("mult_hi_hold", HI, 32'd0);
    busy_phase("mult", 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // Back-to-back issue in the Done cycle: MULTU 0xFFFFFFFE * 3
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    step();
    busy_phase("multu", 5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);
    step();
    check("multu_done_1cyc", {31'd0, Done}, 32'd0);

    // MTHI / MTLO take effect on the next cycle with no Busy or Done
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_stall", {31'd0, StallMD}, 32'd0);
    step();
    check("mthi_hi",   HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    check("mthi_done", {31'd0, Done}, 32'd0);
    issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
    step();
    check("mtlo_lo", LO, 32'hCAFE_F00D);
    check("mtlo_hi", HI, 32'h1234_5678);

    // Reserved opcode does nothing
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("rsv_stall", {31'd0, StallMD}, 32'd0);
    step();
    check("rsv_busy", {31'd0, Busy}, 32'd0);
    check("rsv_hi", HI, 32'h1234_5678);
    check("rsv_lo", LO, 32'hCAFE_F00D);

`ifdef MULDIV_DIV_EN
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_stall_start", {31'd0, StallMD}, 32'd1);
    step();
    busy_phase("div", 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    step();

    issue(MD_DIVU, 32'd7, 32'd2);
    step();
    busy_phase("divu", 10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);
    step();

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    busy_phase("divovf", 10);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);
    step();

    issue(MD_MTHI, 32'h11, 32'd0);
    step();
    issue(MD_MTLO, 32'h22, 32'd0);
    step();
    issue(MD_DIV, 32'd100, 32'd0);
    step();
    busy_phase("div0", 10);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);
    step();
`else
    issue(MD_MTHI, 32'h11, 32'd0);
    step();
    issue(MD_MTLO, 32'h22, 32'd0);
    step();
    issue(MD_DIV, 32'd7, 32'd2);
    check("nodiv_stall", {31'd0, StallMD}, 32'd0);
    step();
    check("nodiv_busy", {31'd0, Busy}, 32'd0);
    for (int i = 0; i < 11; i++) step();
    check("nodiv_busy_late", {31'd0, Busy}, 32'd0);
    check("nodiv_done", {31'd0, Done}, 32'd0);
    check("nodiv_hi", HI, 32'h11);
    check("nodiv_lo", LO, 32'h22);
`endif

    // Reset during the 3rd busy cycle of a MULT discards the result
    issue(MD_MULT, 32'd5, 32'd7);
    step();
    step();
    step();
    check("rstmid_busy_before", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    step();
    check("rstmid_busy", {31'd0, Busy}, 32'd0);
    check("rstmid_done", {31'd0, Done}, 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rstmid_no_done", {31'd0, Done}, 32'd0);
    end
    check("rstmid_lo_late", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
